// File: rtl/norm_shift_pipe.sv
// Post-normalization stage: left-shifts the raw significand by the leading-zero count
// (or clamped to the format's minimum exponent for tiny results). Two-stage valid/ready pipe.
module norm_shift_pipe #(
  parameter logic signed [12:0] EMIN_D = -13'sd1022,
  parameter logic signed [12:0] EMIN_S = -13'sd126
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [56:0] fr,
  input  logic [12:0] er,
  input  logic        db,
  input  logic        tiny,
  input  logic        ovf1,
  input  logic [5:0]  lz,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [56:0] fn,
  output logic [12:0] en,
  output logic        db_o,
  output logic        tiny_o,
  output logic        ovf1_o,
  output logic        zero_o
);

  logic        s1_v_q, s1_v_d;
  logic [56:0] fr1_q, fr1_d;
  logic [5:0]  sh1_q, sh1_d;
  logic [12:0] en1_q, en1_d;
  logic        db1_q, db1_d;
  logic        tiny1_q, tiny1_d;
  logic        ovf1_1_q, ovf1_1_d;
  logic        zero1_q, zero1_d;

  logic        s2_v_q, s2_v_d;
  logic [56:0] fn_q, fn_d;
  logic [12:0] en_q, en_d;
  logic        db2_q, db2_d;
  logic        tiny2_q, tiny2_d;
  logic        ovf1_2_q, ovf1_2_d;
  logic        zero2_q, zero2_d;

  logic               s2_adv;
  logic               accept;
  logic               s1_move;
  logic signed [12:0] emin;
  logic               zero_c;
  logic [5:0]         sh_c;
  logic [12:0]        en_c;

  always_comb begin
    s2_adv   = ~s2_v_q | out_ready;
    in_ready = ~s1_v_q | s2_adv;
    accept   = in_valid & in_ready;
    s1_move  = s1_v_q & s2_adv;
  end

  // Shift amount and exponent; only the low 6 bits of er - emin are needed since it is < lz.
  always_comb begin
    emin   = db ? EMIN_D : EMIN_S;
    zero_c = (lz == 6'd57);
    sh_c   = 6'd0;
    en_c   = er;
    if (zero_c) begin
      sh_c = 6'd0;
      en_c = er;
    end else if (!tiny) begin
      sh_c = lz;
      en_c = er - {7'd0, lz};
    end else if ($signed(er) >= emin) begin
      sh_c = er[5:0] - emin[5:0];
      en_c = emin;
    end
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    fr1_d    = fr1_q;
    sh1_d    = sh1_q;
    en1_d    = en1_q;
    db1_d    = db1_q;
    tiny1_d  = tiny1_q;
    ovf1_1_d = ovf1_1_q;
    zero1_d  = zero1_q;
    if (in_ready) begin
      s1_v_d = in_valid;
    end
    if (accept) begin
      fr1_d    = fr;
      sh1_d    = sh_c;
      en1_d    = en_c;
      db1_d    = db;
      tiny1_d  = tiny;
      ovf1_1_d = ovf1;
      zero1_d  = zero_c;
    end
  end

  always_comb begin
    s2_v_d   = s2_v_q;
    fn_d     = fn_q;
    en_d     = en_q;
    db2_d    = db2_q;
    tiny2_d  = tiny2_q;
    ovf1_2_d = ovf1_2_q;
    zero2_d  = zero2_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
    end
    if (s1_move) begin
      fn_d     = fr1_q << sh1_q;
      en_d     = en1_q;
      db2_d    = db1_q;
      tiny2_d  = tiny1_q;
      ovf1_2_d = ovf1_1_q;
      zero2_d  = zero1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      fr1_q    <= '0;
      sh1_q    <= '0;
      en1_q    <= '0;
      db1_q    <= 1'b0;
      tiny1_q  <= 1'b0;
      ovf1_1_q <= 1'b0;
      zero1_q  <= 1'b0;
      s2_v_q   <= 1'b0;
      fn_q     <= '0;
      en_q     <= '0;
      db2_q    <= 1'b0;
      tiny2_q  <= 1'b0;
      ovf1_2_q <= 1'b0;
      zero2_q  <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      fr1_q    <= fr1_d;
      sh1_q    <= sh1_d;
      en1_q    <= en1_d;
      db1_q    <= db1_d;
      tiny1_q  <= tiny1_d;
      ovf1_1_q <= ovf1_1_d;
      zero1_q  <= zero1_d;
      s2_v_q   <= s2_v_d;
      fn_q     <= fn_d;
      en_q     <= en_d;
      db2_q    <= db2_d;
      tiny2_q  <= tiny2_d;
      ovf1_2_q <= ovf1_2_d;
      zero2_q  <= zero2_d;
    end
  end

  always_comb begin
    out_valid = s2_v_q;
    fn        = fn_q;
    en        = en_q;
    db_o      = db2_q;
    tiny_o    = tiny2_q;
    ovf1_o    = ovf1_2_q;
    zero_o    = zero2_q;
  end

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Scoreboard bench for norm_shift_pipe: directed vectors, backpressure, reset and random traffic
// checked against an arithmetic reference model.
module tb_norm_shift_pipe;

  typedef struct {
    logic [56:0] fn;
    logic [12:0] en;
    logic        db;
    logic        tiny;
    logic        ovf1;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [56:0] fr;
  logic [12:0] er;
  logic        db;
  logic        tiny;
  logic        ovf1;
  logic [5:0]  lz;
  logic        out_valid;
  logic        out_ready;
  logic [56:0] fn;
  logic [12:0] en;
  logic        db_o;
  logic        tiny_o;
  logic        ovf1_o;
  logic        zero_o;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   pop_cyc[$];
  bit   saw_low = 0;
  bit   stall_q = 0;
  logic [56:0] held_fn;
  logic [12:0] held_en;
  bit   rand_done;

  norm_shift_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fr        (fr),
    .er        (er),
    .db        (db),
    .tiny      (tiny),
    .ovf1      (ovf1),
    .lz        (lz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fn        (fn),
    .en        (en),
    .db_o      (db_o),
    .tiny_o    (tiny_o),
    .ovf1_o    (ovf1_o),
    .zero_o    (zero_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [56:0] f, input logic [12:0] e, input logic d,
                                 input logic t, input logic o, input logic [5:0] l);
    exp_t r;
    int ev, emin, sh, eo;
    ev   = int'($signed(e));
    emin = d ? -1022 : -126;
    r.zero = 1'b0;
    if (l == 6'd57) begin
      sh = 0; eo = ev; r.zero = 1'b1;
    end else if (!t) begin
      sh = int'(l); eo = ev - int'(l);
    end else if (ev >= emin) begin
      sh = ev - emin; eo = emin;
    end else begin
      sh = 0; eo = ev;
    end
    r.fn   = f << sh;
    r.en   = 13'(eo);
    r.db   = d;
    r.tiny = t;
    r.ovf1 = o;
    return r;
  endfunction

  // Called just after a rising edge; leaves in_valid high so calls can stream back-to-back.
  task automatic send(input logic [56:0] f, input logic [12:0] e, input logic d, input logic t,
                      input logic o, input logic [5:0] l, input exp_t x);
    bit ok;
    int tries;
    in_valid = 1'b1; fr = f; er = e; db = d; tiny = t; ovf1 = o; lz = l;
    ok = 0;
    tries = 0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        sb.push_back(x);
      end
      @(posedge clk); #1;
      tries++;
    end
    if (!ok) chk("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      stall_q = 0;
    end else begin
      if (in_valid && !in_ready) saw_low = 1;
      if (stall_q) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_fn", 64'(fn), 64'(held_fn));
        chk("stall_en", 64'(en), 64'(held_en));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          x = sb.pop_front();
          pop_cyc.push_back(cyc);
          chk("fn", 64'(fn), 64'(x.fn));
          chk("en", 64'(en), 64'(x.en));
          chk("db_o", 64'(db_o), 64'(x.db));
          chk("tiny_o", 64'(tiny_o), 64'(x.tiny));
          chk("ovf1_o", 64'(ovf1_o), 64'(x.ovf1));
          chk("zero_o", 64'(zero_o), 64'(x.zero));
        end
      end
      stall_q = out_valid && !out_ready;
      held_fn = fn;
      held_en = en;
    end
  end

  function automatic exp_t mk(input logic [56:0] f, input logic [12:0] e, input logic d,
                              input logic t, input logic o, input logic z);
    exp_t r;
    r.fn = f; r.en = e; r.db = d; r.tiny = t; r.ovf1 = o; r.zero = z;
    return r;
  endfunction

  task automatic rand_op();
    logic [63:0] r;
    logic [56:0] f;
    logic [12:0] e;
    logic        d, t, o;
    int          l, emin;
    r = {$urandom, $urandom};
    l = ($urandom_range(0, 9) == 0) ? 57 : $urandom_range(0, 56);
    if (l == 57) begin
      f = '0;
    end else begin
      f = r[56:0] >> l;
      f[56 - l] = 1'b1;
    end
    d    = 1'($urandom);
    o    = 1'($urandom);
    t    = ($urandom_range(0, 2) == 0);
    emin = d ? -1022 : -126;
    e    = 13'($urandom);
    if (t) begin
      if (l > 0 && l < 57 && $urandom_range(0, 1) == 1)
        e = 13'(emin + int'($urandom_range(0, l - 1)));
      else
        e = 13'(emin - 1 - int'($urandom_range(0, 2000)));
    end
    send(f, e, d, t, o, 6'(l), model(f, e, d, t, o, 6'(l)));
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    fr = '0; er = '0; db = 1'b0; tiny = 1'b0; ovf1 = 1'b0; lz = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fn", 64'(fn), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Normal shift, with latency measured from the presenting cycle.
    send(57'h1 << 40, 13'd100, 1'b1, 1'b0, 1'b0, 6'd16, mk(57'h1 << 56, 13'd84, 1, 0, 0, 0));
    idle();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    chk("latency", 64'(n), 64'd2);
    @(posedge clk); #1;
    send(57'h1 << 46, 13'h1F88, 1'b0, 1'b1, 1'b0, 6'd10, mk(57'h1 << 52, 13'h1F82, 0, 1, 0, 0));
    send((57'h1 << 53) | 57'd5, 13'(-1030), 1'b1, 1'b1, 1'b1, 6'd3,
         mk((57'h1 << 53) | 57'd5, 13'(-1030), 1, 1, 1, 0));
    send(57'h0, 13'd5, 1'b0, 1'b0, 1'b0, 6'd57, mk(57'h0, 13'd5, 0, 0, 0, 1));
    idle();
    drain("drain_directed");

    // Backpressure: out_ready low for cycles 3-6 of a 5-op stream.
    saw_low = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) rand_op();
        idle();
      end
      begin
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    chk("in_ready_fell", 64'(saw_low), 64'd1);

    // Full throughput: 8 back-to-back ops give 8 results on consecutive cycles.
    pop_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) rand_op();
    idle();
    drain("drain_throughput");
    chk("throughput_count", 64'(pop_cyc.size()), 64'd8);
    if (pop_cyc.size() == 8) chk("throughput_span", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

    // Reset with two operands in flight.
    out_ready = 1'b0;
    send(57'h1 << 30, 13'd50, 1'b1, 1'b0, 1'b1, 6'd26, mk(57'h1 << 56, 13'd24, 1, 0, 1, 0));
    send(57'h1 << 20, 13'd60, 1'b1, 1'b0, 1'b1, 6'd36, mk(57'h1 << 56, 13'd24, 1, 0, 1, 0));
    idle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_fn", 64'(fn), 64'd0);
    chk("midrst_en", 64'(en), 64'd0);
    chk("midrst_flags", 64'({db_o, tiny_o, ovf1_o, zero_o}), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("postrst_no_stale", 64'(out_valid), 64'd0);

    // Random traffic with random gaps and random downstream stalls.
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          rand_op();
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
        end
        idle();
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
